link_register: RTL and testbench
================================

// Module: link_register
// PURPOSE
//  Parametrised accumulator-class register with a 1-bit link (E) flip-flop.
//  Supports clear, load, increment, decrement and circulate-left/right
//  through the link bit, with carry/borrow captured in the link.
//  Serves as AC/E pair and as general counter register (PC, SC) in the datapath.
// PARAMETERS
//  BITS        16   data width, >= 2
//  RESET_VALUE '0   data_out value applied by reset (BITS wide)
// PORTS
//  clock            in   1     rising-edge clock
//  reset            in   1     asynchronous, active-high reset
//  data_out         out  BITS  register contents
//  link_out         out  1     link (E) bit
//  zero_out         out  1     combinational: data_out == 0
//  data_in          in   BITS  load value
//  clear_in         in   1     data <= 0 (link untouched)
//  load_in          in   1     data <= data_in
//  increment_in     in   1     {link,data} <= data + 1 (link = carry)
//  decrement_in     in   1     {link,data} <= data - 1 (link = borrow)
//  shift_left_in    in   1     circulate left through link
//  shift_right_in   in   1     circulate right through link
//  clear_link_in    in   1     link <= 0
//  complement_link_in in 1     link <= ~link
// BEHAVIOUR
//  - One clock; reset is asynchronous, active-high: data_out <= RESET_VALUE,
//    link_out <= 0 immediately on reset assertion, regardless of clock.
//  - All ops take effect at the rising edge; latency 1 cycle; no strobe = hold.
//  - Data ops, strict priority: clear > load > increment > decrement >
//    shift_left > shift_right. Exactly one data op executes per cycle.
//  - Increment: wraps 2^BITS-1 -> 0, link <= 1 on wrap else 0.
//  - Decrement: wraps 0 -> 2^BITS-1, link <= 1 on wrap (borrow) else 0.
//  - shift_left: data <= {data[BITS-2:0], link}; link <= data[BITS-1].
//  - shift_right: data <= {link, data[BITS-1:1]}; link <= data[0].
//  - Link ops (clear_link > complement_link) apply only when the selected data
//    op does not write link (clear/load/none); otherwise the data op's link
//    result wins.
//  - Reset mid-operation aborts the pending op; first post-reset edge executes
//    the strobes present at that edge.
//  - zero_out is combinational from data_out, independent of link.
// CONFIGURATION
//  - LINK_REGISTER_SHIFT_EN defined: shift_left_in/shift_right_in function as
//    above.
//  - Not defined: shift ports remain but are ignored (treated as no-op, no
//    link change); shift logic not synthesised.
// STRUCTURE
//  - Package link_register_pkg: enum link_op_e {OP_HOLD, OP_CLEAR, OP_LOAD,
//    OP_INC, OP_DEC, OP_SHL, OP_SHR}; function decoding strobes to link_op_e
//    by priority.
//  - Sub-module: two RippleCarryIncrementer instances. One on data_out gives
//    +1 and carry. One on ~data_out gives decrement = ~result and
//    borrow = c_out (set when data == 0).
//  - Single always_ff with async reset; next-state mux selected by link_op_e.
// TESTING (BITS=16, shifts enabled unless noted)
//  1. reset pulse between edges -> data_out=0000, link=0 before next edge;
//     zero_out=1.
//  2. load 0xFFFF, increment -> data=0000, link=1, zero=1;
//     increment -> 0001, link=0.
//  3. load 0x0000, decrement -> data=FFFF, link=1; decrement -> FFFE, link=0.
//  4. load 0x8001, clear_link, shl -> data=0002, link=1;
//     shr -> data=8001, link=0.
//  5. clear+load+inc same edge with data_in=1234 -> data=0000;
//     load+inc (data_in=1234) -> 1234; inc+complement_link -> link=carry only.
//  6. LINK_REGISTER_SHIFT_EN undefined: data=8001, link=0, shl -> data=8001,
//     link=0 (hold).

Source files
------------

// File: rtl/link_register_pkg.sv
// Shared types for the link register: data-op encoding and the strobe
// priority decoder (clear > load > increment > decrement > shl > shr).
package link_register_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6
  } link_op_e;

  // Pick exactly one data op from the strobes, highest priority first.
  function automatic link_op_e decode_op(
    input logic clr,
    input logic ld,
    input logic inc,
    input logic dec,
    input logic shl,
    input logic shr
  );
    if (clr)      return OP_CLEAR;
    else if (ld)  return OP_LOAD;
    else if (inc) return OP_INC;
    else if (dec) return OP_DEC;
    else if (shl) return OP_SHL;
    else if (shr) return OP_SHR;
    else          return OP_HOLD;
  endfunction

endpackage

// File: rtl/link_register_incrementer.sv
// Ripple-carry +1 incrementer. c_out is the carry out of the top bit,
// i.e. set only when the operand is all ones.
module link_register_incrementer #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] operand,
  output logic [BITS-1:0] sum,
  output logic            c_out
);

  logic [BITS:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < BITS; i++) begin : g_ripple
    assign sum[i]       = operand[i] ^ carry[i];
    assign carry[i + 1] = operand[i] & carry[i];
  end

  assign c_out = carry[BITS];

endmodule

// File: rtl/link_register.sv
// Accumulator-class register with a 1-bit link (E) flip-flop.
// Optional feature macro: LINK_REGISTER_SHIFT_EN enables circulate
// left/right through the link; without it the shift strobes are ignored
// and no shift datapath is built.
module link_register
  import link_register_pkg::*;
#(
  parameter int              BITS        = 16,
  parameter logic [BITS-1:0] RESET_VALUE = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [BITS-1:0] data_out,
  output logic            link_out,
  output logic            zero_out,
  input  logic [BITS-1:0] data_in,
  input  logic            clear_in,
  input  logic            load_in,
  input  logic            increment_in,
  input  logic            decrement_in,
  input  logic            shift_left_in,
  input  logic            shift_right_in,
  input  logic            clear_link_in,
  input  logic            complement_link_in
);

  link_op_e        op;
  logic [BITS-1:0] inc_sum;
  logic            inc_carry;
  logic [BITS-1:0] dec_sum_n;
  logic            dec_borrow;
  logic [BITS-1:0] data_next;
  logic            link_next;
  logic            writes_link;

  assign op = decode_op(clear_in, load_in, increment_in, decrement_in,
                        shift_left_in, shift_right_in);

  // data + 1, carry out on wrap from all ones.
  link_register_incrementer #(.BITS(BITS)) u_inc (
    .operand (data_out),
    .sum     (inc_sum),
    .c_out   (inc_carry)
  );

  // ~(~data + 1) == data - 1; the carry fires only when data == 0 (borrow).
  link_register_incrementer #(.BITS(BITS)) u_dec (
    .operand (~data_out),
    .sum     (dec_sum_n),
    .c_out   (dec_borrow)
  );

  // Next-state mux: data op first, then link ops if the data op left link alone.
  always_comb begin
    data_next   = data_out;
    link_next   = link_out;
    writes_link = 1'b0;
    case (op)
      OP_CLEAR: data_next = '0;
      OP_LOAD:  data_next = data_in;
      OP_INC: begin
        data_next   = inc_sum;
        link_next   = inc_carry;
        writes_link = 1'b1;
      end
      OP_DEC: begin
        data_next   = ~dec_sum_n;
        link_next   = dec_borrow;
        writes_link = 1'b1;
      end
`ifdef LINK_REGISTER_SHIFT_EN
      OP_SHL: begin
        data_next   = {data_out[BITS-2:0], link_out};
        link_next   = data_out[BITS-1];
        writes_link = 1'b1;
      end
      OP_SHR: begin
        data_next   = {link_out, data_out[BITS-1:1]};
        link_next   = data_out[0];
        writes_link = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!writes_link) begin
      if (clear_link_in)           link_next = 1'b0;
      else if (complement_link_in) link_next = ~link_out;
    end
  end

  // Register state; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      link_out <= 1'b0;
    end else begin
      data_out <= data_next;
      link_out <= link_next;
    end
  end

  assign zero_out = (data_out == '0);

endmodule

// File: tb/tb_link_register.sv
// Directed bench for link_register (BITS=16). Shift expectations follow
// LINK_REGISTER_SHIFT_EN so the same bench covers both builds.
module tb_link_register;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_out;
  logic        link_out;
  logic        zero_out;
  logic [15:0] data_in = '0;
  logic        clear_in = 0, load_in = 0, increment_in = 0, decrement_in = 0;
  logic        shift_left_in = 0, shift_right_in = 0;
  logic        clear_link_in = 0, complement_link_in = 0;

  int checks = 0;
  int errors = 0;

  link_register #(.BITS(16), .RESET_VALUE(16'h0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .data_out           (data_out),
    .link_out           (link_out),
    .zero_out           (zero_out),
    .data_in            (data_in),
    .clear_in           (clear_in),
    .load_in            (load_in),
    .increment_in       (increment_in),
    .decrement_in       (decrement_in),
    .shift_left_in      (shift_left_in),
    .shift_right_in     (shift_right_in),
    .clear_link_in      (clear_link_in),
    .complement_link_in (complement_link_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clear_in = 0; load_in = 0; increment_in = 0; decrement_in = 0;
    shift_left_in = 0; shift_right_in = 0;
    clear_link_in = 0; complement_link_in = 0;
  endtask

  // One edge, then settle 1 time unit before sampling; strobes dropped after.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic expect_state(input string tag, input logic [15:0] d, input logic l, input logic z);
    check({tag, "_data"}, data_out, d);
    check({tag, "_link"}, {15'b0, link_out}, {15'b0, l});
    check({tag, "_zero"}, {15'b0, zero_out}, {15'b0, z});
  endtask

  initial begin
    // Reset held from time zero
    #1;
    expect_state("por", 16'h0000, 1'b0, 1'b1);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;

    // Load + complement_link: load leaves link free for the link op
    data_in = 16'h5A5A; load_in = 1; complement_link_in = 1;
    tick();
    expect_state("ld5a", 16'h5A5A, 1'b1, 1'b0);

    // Asynchronous reset pulse between edges
    #2 reset = 1;
    #1;
    expect_state("arst", 16'h0000, 1'b0, 1'b1);
    reset = 0;

    // Increment wrap
    data_in = 16'hFFFF; load_in = 1;
    tick();
    check("ldffff", data_out, 16'hFFFF);
    increment_in = 1;
    tick();
    expect_state("incwrap", 16'h0000, 1'b1, 1'b1);
    increment_in = 1;
    tick();
    expect_state("inc1", 16'h0001, 1'b0, 1'b0);

    // Decrement wrap (borrow)
    data_in = 16'h0000; load_in = 1;
    tick();
    check("ld0_zero", {15'b0, zero_out}, 16'h0001);
    decrement_in = 1;
    tick();
    expect_state("decwrap", 16'hFFFF, 1'b1, 1'b0);
    decrement_in = 1;
    tick();
    expect_state("dec1", 16'hFFFE, 1'b0, 1'b0);

    // Circulate through the link
    data_in = 16'h8001; load_in = 1; complement_link_in = 1;
    tick();
    expect_state("ld8001", 16'h8001, 1'b1, 1'b0);
    clear_link_in = 1;
    tick();
    expect_state("clrlink", 16'h8001, 1'b0, 1'b0);
    shift_left_in = 1;
    tick();
`ifdef LINK_REGISTER_SHIFT_EN
    expect_state("shl", 16'h0002, 1'b1, 1'b0);
`else
    expect_state("shl", 16'h8001, 1'b0, 1'b0);
`endif
    shift_right_in = 1;
    tick();
    expect_state("shr", 16'h8001, 1'b0, 1'b0);

    // Data-op priority
    data_in = 16'h1234; clear_in = 1; load_in = 1; increment_in = 1;
    tick();
    expect_state("clrwins", 16'h0000, 1'b0, 1'b1);
    data_in = 16'h1234; load_in = 1; increment_in = 1;
    tick();
    check("ldwins", data_out, 16'h1234);
    increment_in = 1; complement_link_in = 1;
    tick();
    expect_state("inccpl", 16'h1235, 1'b0, 1'b0);
    decrement_in = 1; shift_left_in = 1;
    tick();
    expect_state("decovershl", 16'h1234, 1'b0, 1'b0);

    // Link-op priority: clear_link beats complement_link
    complement_link_in = 1;
    tick();
    check("cpl_link", {15'b0, link_out}, 16'h0001);
    clear_link_in = 1; complement_link_in = 1;
    tick();
    check("clrlink_wins", {15'b0, link_out}, 16'h0000);
    check("link_hold_data", data_out, 16'h1234);

    // Hold with no strobes
    tick();
    check("hold", data_out, 16'h1234);

    // Reset mid-operation: pending strobe executes on first post-reset edge
    increment_in = 1;
    #2 reset = 1;
    #1;
    check("rst_mid_data", data_out, 16'h0000);
    reset = 0;
    @(posedge clock);
    #1;
    idle();
    expect_state("post_rst_inc", 16'h0001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
